// File: rtl/adc_burst_acq_ctrl_if.sv
// Handshake/bus bundle between the fill-size mux, ADC front end, channel buffer
// and the burst acquisition controller.
interface adc_burst_acq_ctrl_if #(
  parameter int unsigned BURST_W = 23
);
  logic               trig;
  logic               size_sel_en;
  logic [BURST_W-1:0] num_fill_bursts;
  logic               adc_valid;
  logic               buf_ready;
  logic               sample_we;
  logic               burst_done;
  logic [BURST_W-1:0] burst_count;
  logic               fill_done;
  logic               busy;
  logic               overflow;
  logic               trig_err;

  modport master (
    output trig, num_fill_bursts, adc_valid, buf_ready,
    input  size_sel_en, sample_we, burst_done, burst_count,
           fill_done, busy, overflow, trig_err
  );

  modport slave (
    input  trig, num_fill_bursts, adc_valid, buf_ready,
    output size_sel_en, sample_we, burst_done, burst_count,
           fill_done, busy, overflow, trig_err
  );
endinterface

// File: rtl/adc_burst_acq_ctrl.sv
// Per-channel burst acquisition controller: selects fill size, gates ADC samples
// into the channel buffer and counts complete bursts until the fill is done.
module adc_burst_acq_ctrl #(
  parameter int unsigned SAMPLES_PER_BURST = 8,
  parameter int unsigned BURST_W           = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adc_burst_acq_ctrl_if.slave  bus
);

  localparam int unsigned      CNT_W       = $clog2(SAMPLES_PER_BURST);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES_PER_BURST - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LOAD,
    ACQ,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [BURST_W-1:0] target;
  logic [BURST_W-1:0] burst_count;
  logic [BURST_W-1:0] burst_count_inc;
  logic [CNT_W-1:0]   sample_cnt;
  logic               burst_done;
  logic               overflow;
  logic               trig_err;

  logic accept;
  logic sample_in;
  logic wrap;
  logic last_burst;

  always_comb begin
    accept          = 1'b0;
    sample_in       = 1'b0;
    wrap            = 1'b0;
    burst_count_inc = burst_count + 1'b1;
    last_burst      = (burst_count_inc == target);
    if (state == IDLE)
      accept = bus.trig;
    if (state == ACQ)
      sample_in = bus.adc_valid;
    wrap = sample_in && (sample_cnt == LAST_SAMPLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.trig) state_nxt = SELECT;
      SELECT:  state_nxt = LOAD;
      LOAD:    state_nxt = (bus.num_fill_bursts == '0) ? DONE : ACQ;
      ACQ:     if (wrap && last_burst) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target      <= '0;
      sample_cnt  <= '0;
      burst_count <= '0;
      burst_done  <= 1'b0;
      overflow    <= 1'b0;
      trig_err    <= 1'b0;
    end else begin
      burst_done <= wrap;
      if (state == LOAD)
        target <= bus.num_fill_bursts;

      // Dropped samples still advance the counter so bursts stay ADC-aligned.
      if (accept)
        sample_cnt <= '0;
      else if (sample_in)
        sample_cnt <= wrap ? '0 : sample_cnt + 1'b1;

      if (accept)
        burst_count <= '0;
      else if (wrap)
        burst_count <= burst_count_inc;

      if (accept)
        overflow <= 1'b0;
      else if (sample_in && !bus.buf_ready)
        overflow <= 1'b1;

      if (accept)
        trig_err <= 1'b0;
      else if (bus.trig && state != IDLE)
        trig_err <= 1'b1;
    end
  end

  assign bus.size_sel_en = (state == SELECT);
  assign bus.sample_we   = sample_in && bus.buf_ready;
  assign bus.burst_done  = burst_done;
  assign bus.burst_count = burst_count;
  assign bus.fill_done   = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.overflow    = overflow;
  assign bus.trig_err    = trig_err;

endmodule

// File: tb/tb_adc_burst_acq_ctrl.sv
// Directed bench for adc_burst_acq_ctrl: one instance per legal burst length,
// cycle indices counted from the trig cycle (cycle 0).
module tb_adc_burst_acq_ctrl;

  localparam int unsigned BW = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trig, adc_valid, buf_ready;
  logic [BW-1:0] nfb;
  logic          sel;

  always #5 clk = ~clk;

  adc_burst_acq_ctrl_if #(.BURST_W(BW)) b8  ();
  adc_burst_acq_ctrl_if #(.BURST_W(BW)) b10 ();

  assign b8.trig             = trig;
  assign b8.adc_valid        = adc_valid;
  assign b8.buf_ready        = buf_ready;
  assign b8.num_fill_bursts  = nfb;
  assign b10.trig            = trig;
  assign b10.adc_valid       = adc_valid;
  assign b10.buf_ready       = buf_ready;
  assign b10.num_fill_bursts = nfb;

  adc_burst_acq_ctrl #(.SAMPLES_PER_BURST(8), .BURST_W(BW)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  adc_burst_acq_ctrl #(.SAMPLES_PER_BURST(10), .BURST_W(BW)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b10)
  );

  logic          o_we, o_bd, o_fd, o_sse, o_busy, o_ovf, o_terr;
  logic [BW-1:0] o_bc;

  assign o_we   = sel ? b10.sample_we   : b8.sample_we;
  assign o_bd   = sel ? b10.burst_done  : b8.burst_done;
  assign o_fd   = sel ? b10.fill_done   : b8.fill_done;
  assign o_sse  = sel ? b10.size_sel_en : b8.size_sel_en;
  assign o_busy = sel ? b10.busy        : b8.busy;
  assign o_ovf  = sel ? b10.overflow    : b8.overflow;
  assign o_terr = sel ? b10.trig_err    : b8.trig_err;
  assign o_bc   = sel ? b10.burst_count : b8.burst_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, n_we, n_bd, n_fd, n_sse;
  int we_first, bd_first, bd_last, fd_cyc, sse_cyc;
  logic fd_busy, busy_after;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; n_we = 0; n_bd = 0; n_fd = 0; n_sse = 0;
    we_first = -1; bd_first = -1; bd_last = -1; fd_cyc = -1; sse_cyc = -1;
    fd_busy = 1'b0; busy_after = 1'b1;
  endtask

  // Inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
  task automatic step(input logic t, input logic v, input logic r);
    @(posedge clk);
    #1;
    trig = t; adc_valid = v; buf_ready = r;
    @(negedge clk);
    if (o_we)  begin n_we++;  if (we_first < 0) we_first = cyc; end
    if (o_bd)  begin n_bd++;  if (bd_first < 0) bd_first = cyc; bd_last = cyc; end
    if (o_fd)  begin n_fd++;  fd_cyc = cyc; fd_busy = o_busy; end
    if (o_sse) begin n_sse++; sse_cyc = cyc; end
    if (fd_cyc >= 0 && cyc == fd_cyc + 1) busy_after = o_busy;
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0; trig = 1'b0; adc_valid = 1'b0; buf_ready = 1'b0;
    nfb = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_bc",   32'(o_bc),   0);
    check("rst_sse",  32'(o_sse),  0);
    check("rst_fd",   32'(o_fd),   0);
    check("rst_flags", {30'd0, o_ovf, o_terr}, 0);
    rst_n = 1'b1;

    // 3 bursts, valid every cycle; buf_ready low before ACQ must not flag overflow
    nfb = 23'd3; clr();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int c = 3; c < 30; c++) step(1'b0, 1'b1, 1'b1);
    check("t1_we",       n_we, 24);
    check("t1_we_first", we_first, 3);
    check("t1_bd",       n_bd, 3);
    check("t1_bd_first", bd_first, 11);
    check("t1_bd_last",  bd_last, 27);
    check("t1_fd_cyc",   fd_cyc, 27);
    check("t1_fd_n",     n_fd, 1);
    check("t1_sse_n",    n_sse, 1);
    check("t1_sse_cyc",  sse_cyc, 1);
    check("t1_bc",       32'(o_bc), 3);
    check("t1_ovf",      32'(o_ovf), 0);
    check("t1_terr",     32'(o_terr), 0);
    check("t1_fd_busy",  32'(fd_busy), 1);
    check("t1_busy_after", 32'(busy_after), 0);

    // zero-burst fill
    nfb = '0; clr();
    step(1'b1, 1'b1, 1'b1);
    for (int c = 1; c < 7; c++) step(1'b0, 1'b1, 1'b1);
    check("t2_fd_cyc", fd_cyc, 3);
    check("t2_we",     n_we, 0);
    check("t2_bd",     n_bd, 0);
    check("t2_sse_n",  n_sse, 1);
    check("t2_bc",     32'(o_bc), 0);

    // 2 bursts with samples 5 and 12 dropped
    nfb = 23'd2; clr();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 16; k++) step(1'b0, 1'b1, (k != 5 && k != 12));
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b1);
    check("t3_we",     n_we, 14);
    check("t3_ovf",    32'(o_ovf), 1);
    check("t3_fd_cyc", fd_cyc, 19);
    check("t3_bd",     n_bd, 2);
    check("t3_bc",     32'(o_bc), 2);
    nfb = '0; clr();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t3_ovf_clear", 32'(o_ovf), 0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0);

    // second trig mid-ACQ is ignored but flagged
    nfb = 23'd3; clr();
    step(1'b1, 1'b1, 1'b1);
    for (int c = 1; c < 30; c++) step(c == 8, 1'b1, 1'b1);
    check("t5_terr",     32'(o_terr), 1);
    check("t5_sse_n",    n_sse, 1);
    check("t5_we",       n_we, 24);
    check("t5_bd",       n_bd, 3);
    check("t5_bd_first", bd_first, 11);
    check("t5_bd_last",  bd_last, 27);
    check("t5_fd_cyc",   fd_cyc, 27);
    check("t5_bc",       32'(o_bc), 3);

    // asynchronous reset in the middle of the second burst
    clr();
    step(1'b1, 1'b1, 1'b1);
    for (int c = 1; c < 14; c++) step(1'b0, 1'b1, 1'b1);
    check("t6_terr_clear", 32'(o_terr), 0);
    check("t6_bc_pre",     32'(o_bc), 1);
    check("t6_we_pre",     32'(o_we), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(o_busy), 0);
    check("t6_rst_we",   32'(o_we), 0);
    check("t6_rst_bc",   32'(o_bc), 0);
    check("t6_rst_outs", {27'd0, o_bd, o_fd, o_sse, o_ovf, o_terr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    for (int c = 0; c < 6; c++) step(1'b0, 1'b1, 1'b1);
    check("t6_no_fd",   n_fd, 0);
    check("t6_no_we",   n_we, 0);
    check("t6_idle",    32'(o_busy), 0);

    // 10-sample bursts with adc_valid toggling
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b1; nfb = 23'd2; clr();
    for (int c = 0; c < 45; c++) step(c == 0, (c % 2) == 1, 1'b1);
    check("t4_we",       n_we, 20);
    check("t4_bd",       n_bd, 2);
    check("t4_bd_first", bd_first, 22);
    check("t4_bd_last",  bd_last, 42);
    check("t4_fd_cyc",   fd_cyc, 42);
    check("t4_bc",       32'(o_bc), 2);
    check("t4_ovf",      32'(o_ovf), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
